// File: rtl/shared_mem_arbiter_if.sv
// rtl/shared_mem_arbiter_if.sv - requester-side bus of the shared memory arbiter
interface shared_mem_arbiter_if #(
  parameter int NUM_REQ    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_wren;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            grant_oh;
  logic [NUM_REQ-1:0]            rvalid_oh;
  logic [DATA_WIDTH-1:0]         rdata;

  // Requester array side
  modport master (
    output req, req_wren, req_lock, req_addr, req_wdata,
    input  grant_oh, rvalid_oh, rdata
  );

  // Arbiter side
  modport slave (
    input  req, req_wren, req_lock, req_addr, req_wdata,
    output grant_oh, rvalid_oh, rdata
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - round-robin arbiter onto shared SRAM and device window (optional MEM_PORT_LOCK_EN)
module shared_mem_arbiter #(
  parameter int NUM_REQ    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int GMEM_AW    = 10,
  parameter int DEV_AW     = 10,
  parameter logic [ADDR_WIDTH-DEV_AW-1:0] DEV_PREFIX = 6'h3F
) (
  input  logic                       clk,
  input  logic                       reset,
  shared_mem_arbiter_if.slave        bus,
  output logic [GMEM_AW-1:0]         gmem_addr,
  output logic                       gmem_we,
  output logic [DATA_WIDTH-1:0]      gmem_wdata,
  input  logic [DATA_WIDTH-1:0]      gmem_q,
  output logic                       device_read_en,
  output logic                       device_write_en,
  output logic [DEV_AW-1:0]          device_addr,
  output logic [DATA_WIDTH-1:0]      device_data_out,
  input  logic [DATA_WIDTH-1:0]      device_data_in,
  input  logic                       device_ready,
  output logic [$clog2(NUM_REQ)-1:0] device_core_id
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {ARB, DEV_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         owner_q, owner_d;
  logic                   hold_rd_q, hold_rd_d;
  logic                   hold_wr_q, hold_wr_d;
  logic [DEV_AW-1:0]      hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
  logic [NUM_REQ-1:0]     rvalid_q, rvalid_d;
  logic                   rd_dev_q, rd_dev_d;
  logic [DATA_WIDTH-1:0]  dev_rdata_q, dev_rdata_d;

  logic [NUM_REQ-1:0]     eligible;
  logic                   lock_active;
  logic                   win_found;
  logic [IDW-1:0]         win_idx;
  logic [IDW-1:0]         cand;
  logic [NUM_REQ-1:0]     win_oh;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_wdata;
  logic                   win_wren;
  logic                   win_dev;
  logic                   arb_sel;
  logic [NUM_REQ-1:0]     grant;
  logic                   complete;
  logic [IDW-1:0]         done_idx;

  // Binary id of a one-hot vector built by OR-ing indices, no priority chain
  function automatic logic [IDW-1:0] oh2bin(input logic [NUM_REQ-1:0] oh);
    logic [IDW-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) b = b | IDW'(i);
    end
    return b;
  endfunction

  // Round-robin successor of an index, wrapping for non-power-of-two counts
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (i == IDW'(NUM_REQ - 1)) return '0;
    return i + 1'b1;
  endfunction

  // Pick the first eligible requester at or after the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh    = win_found ? (NUM_REQ'(1) << win_idx) : '0;
  assign win_addr  = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_wdata = bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign win_wren  = bus.req_wren[win_idx];
  assign win_dev   = (win_addr[ADDR_WIDTH-1:DEV_AW] == DEV_PREFIX);
  assign arb_sel   = (state_q == ARB) && !reset && win_found;

  // Access sequencing: grant/strobe generation and next-state computation
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    hold_rd_d       = hold_rd_q;
    hold_wr_d       = hold_wr_q;
    hold_addr_d     = hold_addr_q;
    hold_data_d     = hold_data_q;
    rvalid_d        = '0;
    rd_dev_d        = rd_dev_q;
    dev_rdata_d     = dev_rdata_q;
    complete        = 1'b0;
    done_idx        = win_idx;
    grant           = '0;
    gmem_we         = 1'b0;
    gmem_addr       = win_addr[GMEM_AW-1:0];
    gmem_wdata      = win_wdata;
    device_read_en  = 1'b0;
    device_write_en = 1'b0;
    device_addr     = win_addr[DEV_AW-1:0];
    device_data_out = win_wdata;
    device_core_id  = '0;
    case (state_q)
      ARB: begin
        if (arb_sel) begin
          device_core_id = oh2bin(win_oh);
          if (win_dev) begin
            device_read_en  = !win_wren;
            device_write_en = win_wren;
          end else begin
            gmem_we = win_wren;
          end
          if (!win_dev || device_ready) begin
            grant    = win_oh;
            complete = 1'b1;
            done_idx = win_idx;
            if (!win_wren) begin
              rvalid_d = win_oh;
              rd_dev_d = win_dev;
            end
            if (win_dev) dev_rdata_d = device_data_in;
          end else begin
            // Device stalled: freeze the access so strobes stay stable while waiting
            state_d     = DEV_WAIT;
            owner_d     = win_idx;
            hold_rd_d   = !win_wren;
            hold_wr_d   = win_wren;
            hold_addr_d = win_addr[DEV_AW-1:0];
            hold_data_d = win_wdata;
          end
        end
      end
      DEV_WAIT: begin
        device_read_en  = hold_rd_q;
        device_write_en = hold_wr_q;
        device_addr     = hold_addr_q;
        device_data_out = hold_data_q;
        device_core_id  = owner_q;
        if (device_ready && !reset) begin
          grant       = NUM_REQ'(1) << owner_q;
          complete    = 1'b1;
          done_idx    = owner_q;
          dev_rdata_d = device_data_in;
          if (hold_rd_q) begin
            rvalid_d = NUM_REQ'(1) << owner_q;
            rd_dev_d = 1'b1;
          end
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
    if (complete && !lock_active) ptr_d = next_idx(done_idx);
  end

  // Sequencer state, pointer and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_rd_q   <= 1'b0;
      hold_wr_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      rvalid_q    <= '0;
      rd_dev_q    <= 1'b0;
      dev_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_rd_q   <= hold_rd_d;
      hold_wr_q   <= hold_wr_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      rvalid_q    <= rvalid_d;
      rd_dev_q    <= rd_dev_d;
      dev_rdata_q <= dev_rdata_d;
    end
  end

  // SRAM data arrives a cycle after its address, so it is routed straight through;
  // device data was captured in the completion cycle
  assign bus.grant_oh  = grant;
  assign bus.rvalid_oh = rvalid_q;
  assign bus.rdata     = (|rvalid_q) ? (rd_dev_q ? dev_rdata_q : gmem_q) : '0;

`ifdef MEM_PORT_LOCK_EN
  logic           lock_valid_q, lock_valid_d;
  logic [IDW-1:0] lock_owner_q, lock_owner_d;

  assign lock_active = lock_valid_q;
  assign eligible    = lock_valid_q ? (bus.req & (NUM_REQ'(1) << lock_owner_q)) : bus.req;

  // Lock ownership: taken on a locked completion, released by an unlocked completion or a req gap
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if ((state_q == ARB) && !reset && lock_valid_q && !bus.req[lock_owner_q]) begin
      lock_valid_d = 1'b0;
    end
    if (complete) begin
      lock_valid_d = bus.req_lock[done_idx];
      lock_owner_d = done_idx;
    end
  end

  // Lock ownership registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q <= 1'b0;
      lock_owner_q <= '0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock;

  assign lock_active = 1'b0;
  assign eligible    = bus.req;
  assign unused_lock = ^bus.req_lock;
`endif

endmodule
